// File: rtl/rggen_irq_coalescer.sv
// Interrupt coalescer over a bank of event-set, register-cleared status bits.
// Define RGGEN_IRQ_COALESCER_PULSE_EN to add the o_irq_pulse output.
module rggen_irq_coalescer #(
  parameter int               WIDTH         = 1,
  parameter logic [WIDTH-1:0] INITIAL_VALUE = '0,
  parameter logic             CLEAR_VALUE   = 1'b1,
  parameter int               COUNT_WIDTH   = 8,
  parameter int               TIMER_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       i_event,
  input  logic [WIDTH-1:0]       i_enable,
  input  logic                   i_command_valid,
  input  logic                   i_select,
  input  logic                   i_write,
  input  logic [WIDTH-1:0]       i_write_data,
  input  logic [WIDTH-1:0]       i_write_mask,
  input  logic [COUNT_WIDTH-1:0] i_threshold,
  input  logic [TIMER_WIDTH-1:0] i_timeout,
  output logic [WIDTH-1:0]       o_status,
  output logic                   o_irq,
  output logic [COUNT_WIDTH-1:0] o_event_count
`ifdef RGGEN_IRQ_COALESCER_PULSE_EN
  ,
  output logic                   o_irq_pulse
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    ASSERT = 2'd2
  } state_e;

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};
  localparam logic [TIMER_WIDTH-1:0] TIMER_MAX = {TIMER_WIDTH{1'b1}};

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       status_q, status_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic                   irq_q;

  logic                   write_valid;
  logic [WIDTH-1:0]       clear_mask;
  logic                   qual;
  logic                   pending;
  logic [COUNT_WIDTH-1:0] thr_eff;
  logic [COUNT_WIDTH-1:0] count_step;
  logic [TIMER_WIDTH-1:0] timer_inc;

  assign write_valid = i_command_valid & i_select & i_write;
  // A bit clears when its write data matches CLEAR_VALUE; a same-cycle event still wins.
  assign clear_mask  = {WIDTH{write_valid}} & i_write_mask
                     & ~(i_write_data ^ {WIDTH{CLEAR_VALUE}});
  assign status_d    = i_event | (status_q & ~clear_mask);

  // pending looks at registered status so a clear only takes effect the cycle after it lands.
  assign qual    = |(i_event & i_enable);
  assign pending = |(status_q & i_enable);
  assign thr_eff = (i_threshold == '0) ? COUNT_WIDTH'(1) : i_threshold;

  assign count_step = (qual && count_q != COUNT_MAX) ? count_q + COUNT_WIDTH'(1) : count_q;
  assign timer_inc  = (timer_q != TIMER_MAX) ? timer_q + TIMER_WIDTH'(1) : timer_q;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    timer_d = timer_q;
    unique case (state_q)
      IDLE: begin
        count_d = '0;
        timer_d = '0;
        if (qual) begin
          count_d = COUNT_WIDTH'(1);
          state_d = (thr_eff <= COUNT_WIDTH'(1)) ? ASSERT : ACCUM;
        end
      end
      ACCUM: begin
        count_d = count_step;
        timer_d = timer_inc;
        if (count_step >= thr_eff) begin
          state_d = ASSERT;
        end else if (i_timeout != '0 && timer_inc >= i_timeout) begin
          state_d = ASSERT;
        end else if (!pending && !qual) begin
          state_d = IDLE;
          count_d = '0;
          timer_d = '0;
        end
      end
      ASSERT: begin
        count_d = count_step;
        if (!pending && !qual) begin
          state_d = IDLE;
          count_d = '0;
          timer_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
        timer_d = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      status_q <= INITIAL_VALUE;
      count_q  <= '0;
      timer_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
      irq_q    <= (state_d == ASSERT);
    end
  end

  assign o_status      = status_q;
  assign o_irq         = irq_q;
  assign o_event_count = count_q;

`ifdef RGGEN_IRQ_COALESCER_PULSE_EN
  logic pulse_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= (state_d == ASSERT) && (state_q != ASSERT);
    end
  end

  assign o_irq_pulse = pulse_q;
`endif

endmodule
